// File: rtl/dma_write_engine.sv
// dma_write_engine
//
// Descriptor-driven DMA write stage. A start command latches a base address
// and a word count; the engine then pops one word at a time from the
// upstream payload FIFO and writes it to the memory port at consecutive
// addresses, raising a one-cycle done pulse when the count is exhausted.
//
// Per-word sequence: READ (pop) -> CAPT (register FIFO data) -> WRITE (hold
// until accepted). At most one pop is ever outstanding, and fifo_rd_en is
// never raised while the FIFO reports empty.
//
// Optional feature macro: DMA_TIMEOUT_EN
//   defined   : a FIFO-starvation counter aborts the transfer after
//               TIMEOUT_CYC empty cycles in READ, pulsing err instead of done.
//   undefined : READ waits indefinitely for data and err is tied low.

module dma_write_engine #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 8,
    parameter int ADDR_STEP   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty_flag,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  words_done_q, words_done_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pop;

`ifdef DMA_TIMEOUT_EN
    localparam int STARVE_W = $clog2(TIMEOUT_CYC + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                err_q, err_d;
`else
    // The starvation limit has no effect when the timeout is compiled out.
    if (TIMEOUT_CYC < 0) begin : g_timeout_unused
    end
`endif

    // A pop is only requested while waiting for a word and data is present.
    assign pop = (state_q == S_READ) && !fifo_empty_flag;

    // Next-state and datapath computation for the whole transfer sequence.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        mem_wr_en_d  = mem_wr_en_q;
        done_d       = 1'b0;
`ifdef DMA_TIMEOUT_EN
        starve_d     = '0;
        err_d        = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_done_d = '0;
                    if (len != '0) begin
                        addr_d      = base_addr;
                        remaining_d = len;
                        state_d     = S_READ;
                    end else begin
                        // Zero-length command: report completion without
                        // touching the FIFO or the memory port.
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_READ: begin
                if (pop) begin
                    state_d = S_CAPT;
                end
`ifdef DMA_TIMEOUT_EN
                else if (starve_q == STARVE_W'(TIMEOUT_CYC - 1)) begin
                    // Starved for the full limit: abort, keep partial count.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    starve_d = starve_q + 1'b1;
                end
`endif
            end

            S_CAPT: begin
                // Popped data is valid this cycle; freeze it for the write.
                wdata_d     = fifo_data;
                mem_wr_en_d = 1'b1;
                state_d     = S_WRITE;
            end

            S_WRITE: begin
                if (mem_ready) begin
                    mem_wr_en_d  = 1'b0;
                    addr_d       = addr_q + ADDR_W'(ADDR_STEP);
                    remaining_d  = remaining_q - 1'b1;
                    words_done_d = words_done_q + 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                mem_wr_en_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            mem_wr_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef DMA_TIMEOUT_EN
            starve_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            mem_wr_en_q  <= mem_wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef DMA_TIMEOUT_EN
            starve_q     <= starve_d;
            err_q        <= err_d;
`endif
        end
    end

    assign fifo_rd_en = pop;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign words_done = words_done_q;
`ifdef DMA_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_dma_write_engine.sv
// Directed testbench for dma_write_engine: behavioural FIFO feeding the
// engine, a write logger on the memory side, and immediate-assertion checks.
module tb_dma_write_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [7:0]  len;
    logic        fifo_rd_en;
    logic [31:0] fifo_data;
    logic        fifo_empty_flag;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  words_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] fifo_mem[$];
    logic [15:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int done_cnt      = 0;
    int err_cnt       = 0;
    int pop_cnt       = 0;
    int rd_empty_viol = 0;

    always #5 clk = ~clk;

    dma_write_engine dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .len             (len),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_data       (fifo_data),
        .fifo_empty_flag (fifo_empty_flag),
        .mem_wr_en       (mem_wr_en),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .words_done      (words_done)
    );

    assign fifo_empty_flag = (fifo_mem.size() == 0);

    // FIFO model (data valid the cycle after a pop) and memory-side logger.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pop_cnt <= pop_cnt + 1;
            if (fifo_mem.size() == 0) rd_empty_viol <= rd_empty_viol + 1;
            else                      fifo_data <= fifo_mem.pop_front();
        end
        if (mem_wr_en && mem_ready) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            step();
            cyc++;
        end
    endtask

    task automatic wait_wr_en(input int budget);
        int n = 0;
        while (!mem_wr_en && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [7:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        int w0, d0, e0, p0, cyc;

        fifo_data = '0;
        rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; mem_ready = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_words", words_done, 0);
        rst = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // Test 1: 10 words at 0x0100, cycle-accurate startup
        for (int i = 0; i < 10; i++) fifo_mem.push_back(32'hD4F40099);
        w0 = wr_addr_log.size(); d0 = done_cnt;
        pulse_start(16'h0100, 8'd10);           // now in cycle 1
        check("t1_busy_c1", busy, 1);
        check("t1_rd_c1", fifo_rd_en, 1);
        step();                                 // cycle 2
        check("t1_rd_c2", fifo_rd_en, 0);
        check("t1_wr_c2", mem_wr_en, 0);
        step();                                 // cycle 3
        check("t1_wr_c3", mem_wr_en, 1);
        check("t1_addr_c3", mem_addr, 32'h0100);
        check("t1_data_c3", mem_wdata, 32'hD4F40099);
        wait_done(200, cyc);
        check("t1_done_cycle", cyc + 3, 31);
        step();
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_busy_fall", busy, 0);
        check("t1_words", words_done, 10);
        check("t1_nwr", wr_addr_log.size() - w0, 10);
        for (int i = 0; i < 10; i++) begin
            check("t1_addr", wr_addr_log[w0 + i], 32'h0100 + 32'(4 * i));
            check("t1_data", wr_data_log[w0 + i], 32'hD4F40099);
        end

        // Test 2: zero-length command
        p0 = pop_cnt; w0 = wr_addr_log.size();
        pulse_start(16'h0200, 8'd0);
        check("t2_done", done, 1);
        check("t2_busy", busy, 1);
        check("t2_rd_en", fifo_rd_en, 0);
        check("t2_wr_en", mem_wr_en, 0);
        step();
        check("t2_done_fall", done, 0);
        check("t2_busy_fall", busy, 0);
        check("t2_pops", pop_cnt - p0, 0);
        check("t2_writes", wr_addr_log.size() - w0, 0);

        // Test 3: stall on word 2 for five cycles
        fifo_mem.push_back(32'h11111111);
        fifo_mem.push_back(32'h22222222);
        fifo_mem.push_back(32'h33333333);
        w0 = wr_addr_log.size();
        pulse_start(16'h0300, 8'd3);
        cyc = 0;
        while (wr_addr_log.size() < w0 + 1 && cyc < 50) begin
            step();
            cyc++;
        end
        check("t3_first_write", wr_addr_log.size() - w0, 1);
        mem_ready = 1'b0;
        wait_wr_en(20);
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_wr_en", mem_wr_en, 1);
            check("t3_stall_addr", mem_addr, 32'h0304);
            check("t3_stall_data", mem_wdata, 32'h22222222);
            step();
        end
        check("t3_stall_nwr", wr_addr_log.size() - w0, 1);
        mem_ready = 1'b1;
        wait_done(50, cyc);
        check("t3_done", done, 1);
        step();
        check("t3_nwr", wr_addr_log.size() - w0, 3);
        check("t3_addr0", wr_addr_log[w0], 32'h0300);
        check("t3_addr1", wr_addr_log[w0 + 1], 32'h0304);
        check("t3_addr2", wr_addr_log[w0 + 2], 32'h0308);
        check("t3_data0", wr_data_log[w0], 32'h11111111);
        check("t3_data1", wr_data_log[w0 + 1], 32'h22222222);
        check("t3_data2", wr_data_log[w0 + 2], 32'h33333333);

        // Test 4: address wrap
        for (int i = 0; i < 3; i++) fifo_mem.push_back(32'hA0000000 + 32'(i));
        w0 = wr_addr_log.size();
        pulse_start(16'hFFFC, 8'd3);
        wait_done(50, cyc);
        step();
        check("t4_nwr", wr_addr_log.size() - w0, 3);
        check("t4_addr0", wr_addr_log[w0], 32'hFFFC);
        check("t4_addr1", wr_addr_log[w0 + 1], 32'h0000);
        check("t4_addr2", wr_addr_log[w0 + 2], 32'h0004);
        check("t4_data2", wr_data_log[w0 + 2], 32'hA0000002);

        // Test 5: second start mid-transfer is ignored
        for (int i = 0; i < 4; i++) fifo_mem.push_back(32'hB0000000 + 32'(i));
        w0 = wr_addr_log.size(); d0 = done_cnt;
        pulse_start(16'h0400, 8'd4);
        repeat (3) step();
        pulse_start(16'h0800, 8'd1);
        wait_done(60, cyc);
        step();
        check("t5_nwr", wr_addr_log.size() - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check("t5_addr", wr_addr_log[w0 + i], 32'h0400 + 32'(4 * i));
            check("t5_data", wr_data_log[w0 + i], 32'hB0000000 + 32'(i));
        end
        check("t5_words", words_done, 4);
        check("t5_done_once", done_cnt - d0, 1);

        // Test 6: FIFO runs dry after 2 of 4 words
        fifo_mem.push_back(32'hC0000001);
        fifo_mem.push_back(32'hC0000002);
        w0 = wr_addr_log.size(); d0 = done_cnt; e0 = err_cnt;
        pulse_start(16'h0500, 8'd4);            // cycle 1
`ifdef DMA_TIMEOUT_EN
        cyc = 1;
        while (!err && cyc < 200) begin
            step();
            cyc++;
        end
        check("t6_err_cycle", cyc, 71);
        check("t6_err", err, 1);
        check("t6_words", words_done, 2);
        step();
        check("t6_err_once", err_cnt - e0, 1);
        check("t6_err_fall", err, 0);
        check("t6_busy", busy, 0);
`else
        repeat (100) step();
        check("t6_busy", busy, 1);
        check("t6_words", words_done, 2);
        check("t6_err", err, 0);
        check("t6_no_err", err_cnt - e0, 0);
`endif
        check("t6_nwr", wr_addr_log.size() - w0, 2);
        check("t6_no_done", done_cnt - d0, 0);

        // Reset in the middle of a stalled write
        mem_ready = 1'b0;
        fifo_mem.push_back(32'hE0000001);
`ifdef DMA_TIMEOUT_EN
        pulse_start(16'h0600, 8'd2);
`endif
        wait_wr_en(20);
        check("rst_mid_wr_en_pre", mem_wr_en, 1);
        check("rst_mid_busy_pre", busy, 1);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_wr_en", mem_wr_en, 0);
        check("rst_mid_rd_en", fifo_rd_en, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_wdata", mem_wdata, 0);
        check("rst_mid_words", words_done, 0);
        step();
        step();
        rst = 1'b1;
        mem_ready = 1'b1;
        step();
        step();
        check("rst_after_busy", busy, 0);
        check("rst_after_wr_en", mem_wr_en, 0);

        check("rd_while_empty", rd_empty_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
